// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and bus-level constants.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_CNT_W  = 4;

  localparam logic                  I2C_ACK      = 1'b0;
  localparam logic                  I2C_NACK     = 1'b1;
  localparam logic [I2C_ADDR_W-1:0] I2C_GEN_CALL = 7'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA input synchronizers plus edge/START/STOP detection, shared by I2C master and target.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  // Chains reset to the idle (released) bus level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // SCL must be stably high on both samples, so an SCL/SDA change in one clk is only an SCL edge.
  assign scl_rise_c = scl_s & ~scl_d;
  assign scl_fall_c = ~scl_s & scl_d;
  assign start_c    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c     = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target endpoint: decodes bus traffic, ACKs its address, moves bytes to/from the user side.
// Optional macro I2C_GEN_CALL_EN: also ACK the general-call write address byte 8'h00.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h01,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_rd,
  output logic       busy,
  output logic       selected,
  output logic       rw
);

  logic sda_s, scl_rise_c, scl_fall_c, start_c, stop_c;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_s      (sda_s),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

  i2c_state_e           state_q, state_nxt;
  logic [7:0]           shift_q, shift_nxt;
  logic [7:0]           tx_sh_q, tx_sh_nxt;
  logic [I2C_CNT_W-1:0] cnt_q, cnt_nxt;
  logic                 sda_oe_nxt, rx_valid_nxt, tx_rd_nxt;
  logic                 busy_nxt, selected_nxt, rw_nxt;
  logic [7:0]           rx_data_nxt;
  logic                 gen_hit_c, addr_hit_c;

`ifdef I2C_GEN_CALL_EN
  assign gen_hit_c = (shift_q == {I2C_GEN_CALL, 1'b0});
`else
  assign gen_hit_c = 1'b0;
`endif
  assign addr_hit_c = (shift_q[7:1] == SLAVE_ADDR) || gen_hit_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= 8'h00;
      tx_sh_q  <= 8'h00;
      cnt_q    <= '0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_rd    <= 1'b0;
      busy     <= 1'b0;
      selected <= 1'b0;
      rw       <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      shift_q  <= shift_nxt;
      tx_sh_q  <= tx_sh_nxt;
      cnt_q    <= cnt_nxt;
      sda_oe   <= sda_oe_nxt;
      rx_data  <= rx_data_nxt;
      rx_valid <= rx_valid_nxt;
      tx_rd    <= tx_rd_nxt;
      busy     <= busy_nxt;
      selected <= selected_nxt;
      rw       <= rw_nxt;
    end
  end

  // Bus conditions first, then per-state SCL edge handling; sda_oe only moves on SCL fall.
  always_comb begin
    state_nxt    = state_q;
    shift_nxt    = shift_q;
    tx_sh_nxt    = tx_sh_q;
    cnt_nxt      = cnt_q;
    sda_oe_nxt   = sda_oe;
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    tx_rd_nxt    = 1'b0;
    busy_nxt     = busy;
    selected_nxt = selected;
    rw_nxt       = rw;

    if (start_c) begin
      state_nxt    = ST_ADDR;
      cnt_nxt      = '0;
      busy_nxt     = 1'b1;
      selected_nxt = 1'b0;
      sda_oe_nxt   = 1'b0;
    end else if (stop_c) begin
      state_nxt    = ST_IDLE;
      busy_nxt     = 1'b0;
      selected_nxt = 1'b0;
      sda_oe_nxt   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_WR_DATA: begin
          if (scl_rise_c) begin
            shift_nxt = {shift_q[6:0], sda_s};
            cnt_nxt   = cnt_q + I2C_CNT_W'(1);
          end else if (scl_fall_c && cnt_q == I2C_CNT_W'(8)) begin
            if (state_q == ST_WR_DATA) begin
              rx_data_nxt  = shift_q;
              rx_valid_nxt = 1'b1;
              sda_oe_nxt   = 1'b1;
              state_nxt    = ST_WR_ACK;
            end else if (addr_hit_c) begin
              sda_oe_nxt   = 1'b1;
              rw_nxt       = shift_q[0];
              selected_nxt = 1'b1;
              state_nxt    = ST_ADDR_ACK;
            end else begin
              state_nxt = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK, ST_WR_ACK: begin
          if (scl_fall_c) begin
            cnt_nxt = '0;
            if (state_q == ST_ADDR_ACK && rw) begin
              tx_sh_nxt  = tx_data;
              tx_rd_nxt  = 1'b1;
              sda_oe_nxt = ~tx_data[7];
              state_nxt  = ST_RD_DATA;
            end else begin
              sda_oe_nxt = 1'b0;
              state_nxt  = ST_WR_DATA;
            end
          end
        end
        ST_RD_DATA: begin
          if (scl_fall_c) begin
            if (cnt_q == I2C_CNT_W'(7)) begin
              sda_oe_nxt = 1'b0;
              state_nxt  = ST_RD_ACK;
            end else begin
              tx_sh_nxt  = {tx_sh_q[6:0], 1'b0};
              sda_oe_nxt = ~tx_sh_q[6];
              cnt_nxt    = cnt_q + I2C_CNT_W'(1);
            end
          end
        end
        ST_RD_ACK: begin
          // A NACK leaves on the rise, so any fall seen here follows a master ACK.
          if (scl_rise_c && sda_s == I2C_NACK) begin
            sda_oe_nxt = 1'b0;
            state_nxt  = ST_WAIT_STOP;
          end else if (scl_fall_c) begin
            tx_sh_nxt  = tx_data;
            tx_rd_nxt  = 1'b1;
            sda_oe_nxt = ~tx_data[7];
            cnt_nxt    = '0;
            state_nxt  = ST_RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master driving i2c_slave, checked against a transaction-level model.
module tb_i2c_slave;

  localparam int unsigned Q   = 6;
  localparam logic [6:0]  OWN = 7'h01;
`ifdef I2C_GEN_CALL_EN
  localparam bit GEN_EN = 1'b1;
`else
  localparam bit GEN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, rx_valid, tx_rd, busy, selected, rw;
  logic [7:0] rx_data, tx_data;

  logic [7:0] src [0:15];
  logic [7:0] rx_log [0:255];
  int         rx_cnt = 0;
  int         tx_cnt = 0;
  int         tx_base = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] tx_idx;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;
  assign tx_idx  = 4'(tx_cnt - tx_base);
  assign tx_data = src[tx_idx];

  i2c_slave #(.SLAVE_ADDR(OWN), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_m),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_rd    (tx_rd),
    .busy     (busy),
    .selected (selected),
    .rw       (rw)
  );

  // Log every delivered byte and every fetch from the user side.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt % 256] = rx_data;
      rx_cnt = rx_cnt + 1;
    end
    if (tx_rd) tx_cnt = tx_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    tick(Q); sda_m = b;
    tick(Q); scl_m = 1'b1;
    tick(Q); s = sda_bus;
    tick(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(nack, s);
  endtask

  function automatic bit addr_match(input logic [7:0] a);
    return (a[7:1] == OWN) || (GEN_EN && a == 8'h00);
  endfunction

  // One transfer: address byte then n data bytes from/to src[], with model-derived expectations.
  task automatic txn(input logic [7:0] abyte, input int n, input bit do_stop);
    logic       ack;
    logic [7:0] d;
    bit         hit;
    int         rx_base;
    hit     = addr_match(abyte);
    rx_base = rx_cnt;
    tx_base = tx_cnt;
    i2c_start();
    check("busy_after_start", 32'(busy), 32'd1);
    write_byte(abyte, ack);
    check("addr_ack", 32'(ack), hit ? 32'd0 : 32'd1);
    check("selected", 32'(selected), 32'(hit));
    if (hit) check("rw", 32'(rw), 32'(abyte[0]));
    if (hit && abyte[0]) begin
      for (int i = 0; i < n; i++) begin
        read_byte(i == n - 1, d);
        check("rd_byte", 32'(d), 32'(src[i]));
      end
      check("sda_released_after_nack", 32'(sda_oe), 32'd0);
      check("tx_rd_count", 32'(tx_cnt - tx_base), 32'(n));
    end else begin
      for (int i = 0; i < n; i++) begin
        write_byte(src[i], ack);
        check("data_ack", 32'(ack), hit ? 32'd0 : 32'd1);
      end
      check("rx_count", 32'(rx_cnt - rx_base), hit ? 32'(n) : 32'd0);
      if (hit)
        for (int i = 0; i < n; i++)
          check("rx_data", 32'(rx_log[(rx_base + i) % 256]), 32'(src[i]));
    end
    if (do_stop) begin
      i2c_stop();
      check("busy_after_stop", 32'(busy), 32'd0);
      check("selected_after_stop", 32'(selected), 32'd0);
      check("sda_oe_after_stop", 32'(sda_oe), 32'd0);
    end
  endtask

  initial begin
    logic       s;
    logic       ack;
    logic [7:0] a;
    int         n;
    int         rx_keep;

    for (int i = 0; i < 16; i++) src[i] = 8'h00;
    tick(3);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_rd", 32'(tx_rd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_selected", 32'(selected), 32'd0);
    check("rst_rw", 32'(rw), 32'd0);
    rst = 1'b0;
    tick(4);

    // Directed: write A5, read 3C/C3, foreign address, repeated START
    src[0] = 8'hA5; txn(8'h02, 1, 1'b1);
    src[0] = 8'h3C; src[1] = 8'hC3; txn(8'h03, 2, 1'b1);
    src[0] = 8'h77; txn(8'h54, 1, 1'b1);
    src[0] = 8'h11; txn(8'h02, 1, 1'b0);
    src[0] = 8'h96; txn(8'h03, 1, 1'b1);

    // Reset in the middle of a data byte
    i2c_start();
    write_byte(8'h02, ack);
    check("pre_rst_ack", 32'(ack), 32'd0);
    rx_keep = rx_cnt;
    for (int i = 0; i < 4; i++) bit_xfer(1'b0, s);
    rst = 1'b1;
    tick(1);
    check("midrst_sda_oe", 32'(sda_oe), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_selected", 32'(selected), 32'd0);
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    tick(4 * Q);
    check("midrst_no_rx", 32'(rx_cnt - rx_keep), 32'd0);
    src[0] = 8'h4E; txn(8'h02, 1, 1'b1);

    // General call byte 8'h00: ACKed only when enabled
    src[0] = 8'h5A; txn(8'h00, 1, 1'b1);

    // Randomized transfers
    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 3))
        0:       a = {OWN, 1'b0};
        1:       a = {OWN, 1'b1};
        2:       a = 8'h00;
        default: a = 8'($urandom);
      endcase
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < 16; i++) src[i] = 8'($urandom);
      txn(a, n, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
